sprite_line_scheduler: RTL and testbench

SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

---
 rtl/sprite_pkg.sv | 34 +++
 rtl/sprite_table.sv | 38 +++
 rtl/sprite_line_scheduler.sv | 170 +++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and default constants for the sprite line scheduler:
// table entry layout, captured hit record and the scheduler FSM states.
package sprite_pkg;

  localparam int ID_W    = 5;
  localparam int COORD_W = 10;
  localparam int DIM_W   = 5;
  localparam int RGB_W   = 24;

  localparam int DEF_NUM_SPRITES  = 20;
  localparam int DEF_MAX_PER_LINE = 4;
  localparam int DEF_SPR_DIM      = 32;
  localparam int DEF_H_ACTIVE     = 640;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } sprite_entry_t;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [COORD_W-1:0] x;
    logic [DIM_W-1:0]   row;
  } hit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FETCH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sprite_table.sv
// Shadow/active sprite table pair: the CPU writes the shadow copy at any time,
// frame_sync copies it wholesale into the active copy that the scanner reads.
module sprite_table
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = DEF_NUM_SPRITES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [4:0]    idx,
  input  sprite_entry_t wdata,
  input  logic          load,
  input  logic [4:0]    rd_idx,
  output sprite_entry_t rd_data
);

  sprite_entry_t shadow [NUM_SPRITES];
  sprite_entry_t active [NUM_SPRITES];

  // NOTE: both tables are flop arrays, not RAM, so they can and must be
  // cleared by reset; an empty table (all id 0) means nothing is drawn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      // A write in the load cycle lands in shadow only: active takes the old shadow.
      if (we && (32'(idx) < NUM_SPRITES)) shadow[idx] <= wdata;
      if (load) active <= shadow;
    end
  end

  assign rd_data = (32'(rd_idx) < NUM_SPRITES) ? active[rd_idx] : '0;

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the active table for sprites covering
// the next line, then streams their pixel rows from ROM into the line buffer.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES  = DEF_NUM_SPRITES,
  parameter int MAX_PER_LINE = DEF_MAX_PER_LINE,
  parameter int SPR_DIM      = DEF_SPR_DIM,
  parameter int H_ACTIVE     = DEF_H_ACTIVE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tbl_we,
  input  logic [4:0]  tbl_idx,
  input  logic [24:0] tbl_data,
  input  logic        frame_sync,
  input  logic        line_start,
  input  logic [9:0]  line_y,
  output logic [4:0]  rom_id,
  output logic [9:0]  rom_addr,
  input  logic [23:0] rom_q,
  output logic        lb_we,
  output logic [9:0]  lb_addr,
  output logic [23:0] lb_data,
  output logic        busy,
  output logic        line_done,
  output logic        overflow,
  output logic        late
);

  localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
  localparam int HIT_W = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

  state_t             state, state_nxt;
  logic [4:0]         scan_idx;
  logic [9:0]         line_q;
  hit_t               hits [MAX_PER_LINE];
  logic [CNT_W-1:0]   hit_cnt;
  logic [HIT_W-1:0]   fetch_hit;
  logic [DIM_W-1:0]   col;
  logic               drain;
  logic               pipe_valid;
  logic [10:0]        pipe_addr;

  sprite_entry_t      scan_ent;
  hit_t               cur;
  logic               hit;
  logic [DIM_W-1:0]   hit_row;
  logic               last_scan, last_col, last_hit, issue;

  sprite_table #(.NUM_SPRITES(NUM_SPRITES)) u_table (
    .clk     (clk),
    .reset   (reset),
    .we      (tbl_we),
    .idx     (tbl_idx),
    .wdata   (tbl_data),
    .load    (frame_sync),
    .rd_idx  (scan_idx),
    .rd_data (scan_ent)
  );

  assign cur       = hits[fetch_hit];
  assign last_scan = (scan_idx == 5'(NUM_SPRITES - 1));
  assign last_col  = (col == DIM_W'(SPR_DIM - 1));
  assign last_hit  = (CNT_W'(fetch_hit) == hit_cnt - CNT_W'(1));
  assign issue     = (state == ST_FETCH) && !drain;

  // Vertical hit test widened to 11 bits so y+SPR_DIM near 1023 cannot wrap.
  always_comb begin
    logic [10:0] ly11, y11, diff;
    ly11    = {1'b0, line_q};
    y11     = {1'b0, scan_ent.y};
    diff    = ly11 - y11;
    hit     = (scan_ent.id != '0) && (ly11 >= y11) && (ly11 < y11 + 11'(SPR_DIM));
    hit_row = diff[DIM_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets its default before the case, so no
  // path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (line_start) state_nxt = ST_SCAN;
      ST_SCAN:  if (last_scan) state_nxt = (hit_cnt != '0 || hit) ? ST_FETCH : ST_DONE;
      ST_FETCH: if (drain) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_idx   <= '0;
      line_q     <= '0;
      hit_cnt    <= '0;
      fetch_hit  <= '0;
      col        <= '0;
      drain      <= 1'b0;
      pipe_valid <= 1'b0;
      pipe_addr  <= '0;
      line_done  <= 1'b0;
      overflow   <= 1'b0;
      late       <= 1'b0;
      for (int i = 0; i < MAX_PER_LINE; i++) hits[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (line_start) begin
            line_q   <= line_y;
            hit_cnt  <= '0;
            overflow <= 1'b0;
            scan_idx <= '0;
          end
        end
        ST_SCAN: begin
          scan_idx <= scan_idx + 5'd1;
          if (hit) begin
            if (32'(hit_cnt) < MAX_PER_LINE) begin
              hits[hit_cnt[HIT_W-1:0]] <= '{id: scan_ent.id, x: scan_ent.x, row: hit_row};
              hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
              overflow <= 1'b1;
            end
          end
          if (last_scan) begin
            fetch_hit <= '0;
            col       <= '0;
            drain     <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (!drain) begin
            if (last_col) begin
              col <= '0;
              if (last_hit) drain <= 1'b1;
              else          fetch_hit <= fetch_hit + HIT_W'(1);
            end else begin
              col <= col + DIM_W'(1);
            end
          end
        end
        default: ;
      endcase

      // Line-buffer address is delayed one cycle to line up with rom_q.
      pipe_valid <= issue;
      if (issue) pipe_addr <= {1'b0, cur.x} + 11'(col);

      line_done <= (state == ST_DONE);

      if (line_start && state != ST_IDLE) late <= 1'b1;
      else if (frame_sync)                late <= 1'b0;
    end
  end

  assign busy     = (state != ST_IDLE);
  assign rom_id   = issue ? cur.id : '0;
  assign rom_addr = issue ? {cur.row, col} : '0;
  assign lb_we    = pipe_valid && (rom_q != '0) && (pipe_addr < 11'(H_ACTIVE));
  assign lb_addr  = pipe_addr[9:0];
  assign lb_data  = pipe_valid ? rom_q : '0;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler: a vector table of whole-line
// scenarios plus hand-written sequences for table buffering, late and reset.
module tb_sprite_line_scheduler;

  logic        clk, reset;
  logic        tbl_we, frame_sync, line_start;
  logic [4:0]  tbl_idx;
  logic [24:0] tbl_data;
  logic [9:0]  line_y;
  logic [4:0]  rom_id;
  logic [9:0]  rom_addr;
  logic [23:0] rom_q;
  logic        lb_we, busy, line_done, overflow, late;
  logic [9:0]  lb_addr;
  logic [23:0] lb_data;

  sprite_line_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .tbl_we     (tbl_we),
    .tbl_idx    (tbl_idx),
    .tbl_data   (tbl_data),
    .frame_sync (frame_sync),
    .line_start (line_start),
    .line_y     (line_y),
    .rom_id     (rom_id),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .lb_we      (lb_we),
    .lb_addr    (lb_addr),
    .lb_data    (lb_data),
    .busy       (busy),
    .line_done  (line_done),
    .overflow   (overflow),
    .late       (late)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: id 7, col 5 is transparent; everything else is nonzero.
  function automatic logic [23:0] rom_f(input logic [4:0] id, input logic [9:0] addr);
    if (id == 5'd7 && addr[4:0] == 5'd5) return 24'h0;
    return {3'b101, id, 6'b0, addr};
  endfunction

  always @(posedge clk) rom_q <= rom_f(rom_id, rom_addr);

  // Observed line statistics and a line-buffer image.
  int          n_wr;
  logic [9:0]  first_wa, last_wa;
  logic        seen_rom;
  logic [4:0]  first_rid;
  logic [9:0]  first_raddr;
  logic [23:0] lbm [1024];

  always @(negedge clk) begin
    if (lb_we) begin
      lbm[lb_addr] <= lb_data;
      n_wr         <= n_wr + 1;
      if (n_wr == 0) first_wa <= lb_addr;
      last_wa <= lb_addr;
    end
    if (rom_id != 5'd0 && !seen_rom) begin
      seen_rom    <= 1'b1;
      first_rid   <= rom_id;
      first_raddr <= rom_addr;
    end
  end

  int nvec  = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] ent(input int id, input int x, input int y);
    return {5'(id), 10'(x), 10'(y)};
  endfunction

  task automatic clear_stats();
    n_wr = 0; first_wa = '0; last_wa = '0;
    seen_rom = 1'b0; first_rid = '0; first_raddr = '0;
  endtask

  task automatic write_entry(input int idx, input logic [24:0] d);
    tbl_we = 1'b1; tbl_idx = 5'(idx); tbl_data = d;
    @(posedge clk); #1;
    tbl_we = 1'b0;
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < 20; i++) write_entry(i, 25'd0);
  endtask

  task automatic pulse_frame();
    frame_sync = 1'b1;
    @(posedge clk); #1;
    frame_sync = 1'b0;
  endtask

  // Starts a line and returns the cycle on which line_done is seen (line_start
  // is cycle 0); optionally re-pulses line_start at cycle 'inject'.
  task automatic run_line(input logic [9:0] ly, input int inject, output int lat);
    clear_stats();
    line_start = 1'b1; line_y = ly;
    lat = -1;
    for (int c = 1; c <= 300 && lat < 0; c++) begin
      @(posedge clk); #1;
      line_start = (c == inject);
      @(negedge clk);
      if (c == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (line_done) lat = c;
    end
    if (lat < 0) begin
      nvec++; nfail++;
      $display("FAIL line_done_timeout: got none within 300 cycles, expected a pulse");
    end
    @(negedge clk);
    check("line_done_one_cycle", 32'(line_done), 32'd0);
    check("busy_back_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  typedef struct packed {
    logic [2:0]       n;
    logic [5:0][4:0]  idx;
    logic [5:0][24:0] ents;
    logic [9:0]       ly;
    logic [7:0]       lat;
    logic             ovf;
    logic [7:0]       writes;
    logic [9:0]       fa;
    logic [9:0]       la;
    logic [4:0]       rid;
    logic [9:0]       raddr;
  } vec_t;

  function automatic vec_t mkv(input int n, input int ly, input int lat, input int ovf,
                               input int wr, input int fa, input int la, input int rid,
                               input int raddr);
    vec_t v;
    v = '0;
    v.n = 3'(n); v.ly = 10'(ly); v.lat = 8'(lat); v.ovf = 1'(ovf); v.writes = 8'(wr);
    v.fa = 10'(fa); v.la = 10'(la); v.rid = 5'(rid); v.raddr = 10'(raddr);
    return v;
  endfunction

  localparam int NV = 10;
  vec_t vt [NV];
  int   lat;

  initial begin
    reset = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_data = '0;
    frame_sync = 1'b0; line_start = 1'b0; line_y = '0;
    for (int i = 0; i < 1024; i++) lbm[i] = '0;
    clear_stats();

    // Single sprite at row 10.
    vt[0] = mkv(1, 60, 55, 0, 32, 100, 131, 1, 320);
    vt[0].idx[0] = 5'd0; vt[0].ents[0] = ent(1, 100, 50);
    // Six overlapping sprites: first four drawn, overflow.
    vt[1] = mkv(6, 60, 151, 1, 128, 0, 151, 1, 320);
    for (int k = 0; k < 6; k++) begin
      vt[1].idx[k] = 5'(k); vt[1].ents[k] = ent(k + 1, 40 * k, 50 + k);
    end
    // Right-edge clipping plus transparent pixel at col 5.
    vt[2] = mkv(1, 60, 55, 0, 19, 620, 639, 7, 0);
    vt[2].idx[0] = 5'd3; vt[2].ents[0] = ent(7, 620, 60);
    // line_y == y + SPR_DIM: just below the sprite, no hit.
    vt[3] = mkv(1, 82, 22, 0, 0, 0, 0, 0, 0);
    vt[3].idx[0] = 5'd0; vt[3].ents[0] = ent(1, 100, 50);
    // Last table entry, bottom row 31.
    vt[4] = mkv(1, 91, 55, 0, 32, 10, 41, 2, 992);
    vt[4].idx[0] = 5'd19; vt[4].ents[0] = ent(2, 10, 60);
    // id 0 never hits.
    vt[5] = mkv(1, 60, 22, 0, 0, 0, 0, 0, 0);
    vt[5].idx[0] = 5'd0; vt[5].ents[0] = ent(0, 100, 50);
    // y near 1023 must not wrap.
    vt[6] = mkv(1, 1020, 55, 0, 32, 0, 31, 4, 640);
    vt[6].idx[0] = 5'd5; vt[6].ents[0] = ent(4, 0, 1000);
    // Exactly MAX_PER_LINE hits: no overflow.
    vt[7] = mkv(4, 60, 151, 0, 128, 0, 331, 1, 0);
    for (int k = 0; k < 4; k++) begin
      vt[7].idx[k] = 5'(2 + 4 * k); vt[7].ents[k] = ent(k + 1, 100 * k, 60 - k);
    end
    // Out-of-range table index is ignored.
    vt[8] = mkv(1, 60, 22, 0, 0, 0, 0, 0, 0);
    vt[8].idx[0] = 5'd24; vt[8].ents[0] = ent(1, 0, 60);
    // line_y one above the sprite top.
    vt[9] = mkv(1, 49, 22, 0, 0, 0, 0, 0, 0);
    vt[9].idx[0] = 5'd0; vt[9].ents[0] = ent(1, 100, 50);

    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_lb_we", 32'(lb_we), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_late", 32'(late), 32'd0);
    check("rst_rom_id", 32'(rom_id), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_lb_addr", 32'(lb_addr), 32'd0);
    check("rst_lb_data", 32'(lb_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) begin
      clear_shadow();
      for (int k = 0; k < int'(vt[v].n); k++) write_entry(int'(vt[v].idx[k]), vt[v].ents[k]);
      pulse_frame();
      run_line(vt[v].ly, -1, lat);
      check($sformatf("v%0d_latency", v), 32'(lat), 32'(vt[v].lat));
      check($sformatf("v%0d_overflow", v), 32'(overflow), 32'(vt[v].ovf));
      check($sformatf("v%0d_writes", v), 32'(n_wr), 32'(vt[v].writes));
      check($sformatf("v%0d_first_lb_addr", v), 32'(first_wa), 32'(vt[v].fa));
      check($sformatf("v%0d_last_lb_addr", v), 32'(last_wa), 32'(vt[v].la));
      check($sformatf("v%0d_first_rom_id", v), 32'(first_rid), 32'(vt[v].rid));
      check($sformatf("v%0d_first_rom_addr", v), 32'(first_raddr), 32'(vt[v].raddr));
    end

    // Shadow writes stay invisible until frame_sync.
    clear_shadow();
    write_entry(0, ent(1, 100, 50));
    pulse_frame();
    write_entry(0, ent(2, 200, 50));
    run_line(10'd60, -1, lat);
    check("shadow_old_rom_id", 32'(first_rid), 32'd1);
    check("shadow_old_lb_addr", 32'(first_wa), 32'd100);
    pulse_frame();
    run_line(10'd60, -1, lat);
    check("shadow_new_rom_id", 32'(first_rid), 32'd2);
    check("shadow_new_lb_addr", 32'(first_wa), 32'd200);
    // Write coinciding with frame_sync goes to shadow only.
    tbl_we = 1'b1; tbl_idx = 5'd1; tbl_data = ent(3, 300, 50); frame_sync = 1'b1;
    @(posedge clk); #1;
    tbl_we = 1'b0; frame_sync = 1'b0;
    run_line(10'd60, -1, lat);
    check("same_cycle_writes", 32'(n_wr), 32'd32);
    check("same_cycle_latency", 32'(lat), 32'd55);
    pulse_frame();
    run_line(10'd60, -1, lat);
    check("two_hit_latency", 32'(lat), 32'd87);
    check("two_hit_writes", 32'(n_wr), 32'd64);
    check("two_hit_last_addr", 32'(last_wa), 32'd331);

    // Overlap: higher index drawn on top.
    clear_shadow();
    write_entry(0, ent(1, 100, 60));
    write_entry(1, ent(2, 110, 60));
    pulse_frame();
    run_line(10'd60, -1, lat);
    check("overlap_px105", 32'(lbm[105]), 32'(rom_f(5'd1, 10'd5)));
    check("overlap_px115", 32'(lbm[115]), 32'(rom_f(5'd2, 10'd5)));
    check("overlap_px141", 32'(lbm[141]), 32'(rom_f(5'd2, 10'd31)));

    // line_start during FETCH is ignored and flags late until frame_sync.
    clear_shadow();
    write_entry(0, ent(1, 100, 50));
    pulse_frame();
    run_line(10'd60, 30, lat);
    check("late_latency", 32'(lat), 32'd55);
    check("late_writes", 32'(n_wr), 32'd32);
    check("late_last_addr", 32'(last_wa), 32'd131);
    check("late_set", 32'(late), 32'd1);
    pulse_frame();
    @(negedge clk);
    check("late_cleared", 32'(late), 32'd0);
    @(posedge clk); #1;

    // Reset asserted mid-FETCH with overflow and late both set.
    clear_shadow();
    for (int k = 0; k < 6; k++) write_entry(k, ent(k + 1, 40 * k, 50 + k));
    pulse_frame();
    line_start = 1'b1; line_y = 10'd60;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      line_start = (c == 10);
    end
    @(negedge clk);
    check("pre_reset_overflow", 32'(overflow), 32'd1);
    check("pre_reset_late", 32'(late), 32'd1);
    check("pre_reset_lb_we", 32'(lb_we), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_lb_we", 32'(lb_we), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_late", 32'(late), 32'd0);
    check("mid_rst_rom_id", 32'(rom_id), 32'd0);
    check("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    check("mid_rst_lb_addr", 32'(lb_addr), 32'd0);
    check("mid_rst_lb_data", 32'(lb_data), 32'd0);
    check("mid_rst_line_done", 32'(line_done), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    clear_stats();
    begin
      int active_cycles;
      active_cycles = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (lb_we || busy) active_cycles++;
      end
      check("post_reset_quiet", 32'(active_cycles), 32'd0);
    end
    @(posedge clk); #1;
    run_line(10'd60, -1, lat);
    check("post_reset_active_empty", 32'(lat), 32'd22);
    pulse_frame();
    run_line(10'd60, -1, lat);
    check("post_reset_shadow_empty", 32'(lat), 32'd22);
    check("post_reset_writes", 32'(n_wr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
